// File: rtl/clk_gate_if.sv
// Handshake bundle between clock requesters and the clk_gate_ctrl enable generator.
`timescale 1ns/1ps
interface clk_gate_if;
    logic       run_req;
    logic       busy;
    logic       force_on;
    logic       clk_en;
    logic       clk_ack;
    logic [1:0] state_o;

    modport master (
        output run_req, busy, force_on,
        input  clk_en, clk_ack, state_o
    );

    modport slave (
        input  run_req, busy, force_on,
        output clk_en, clk_ack, state_o
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Registered, glitch-free enable generator for clk_gating with wake settle and idle hysteresis.
// Define CLK_GATE_STAT_EN to add the saturating gated_cycles counter and its stat_clr input.
`timescale 1ns/1ps
module clk_gate_ctrl #(
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned CNT_W       = 8
) (
    input logic       in_clk,
    input logic       rst,
    clk_gate_if.slave gif
`ifdef CLK_GATE_STAT_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] gated_cycles
`endif
);
    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StWake = 2'd1,
        StOn   = 2'd2,
        StIdle = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] WakeLoad = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IdleLoad = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic             clk_en_q, clk_en_d;
    logic             clk_ack_q, clk_ack_d;
    logic             act;

    assign act = gif.run_req | gif.busy | gif.force_on;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        icnt_d  = icnt_q;
        unique case (state_q)
            StOff: begin
                if (act) begin
                    state_d = StWake;
                    wcnt_d  = WakeLoad;
                end
            end
            // Wake always runs to completion so clk_ack only follows a settled clock.
            StWake: begin
                if (wcnt_q == '0) state_d = StOn;
                else              wcnt_d  = wcnt_q - CntOne;
            end
            StOn: begin
                if (!act) begin
                    state_d = StIdle;
                    icnt_d  = IdleLoad;
                end
            end
            StIdle: begin
                if (act)                 state_d = StOn;
                else if (icnt_q == '0)   state_d = StOff;
                else                     icnt_d  = icnt_q - CntOne;
            end
        endcase
        // Outputs are decoded from the next state and registered alongside it.
        clk_en_d  = (state_d != StOff);
        clk_ack_d = (state_d == StOn) || (state_d == StIdle);
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            state_q   <= StOff;
            wcnt_q    <= '0;
            icnt_q    <= '0;
            clk_en_q  <= 1'b0;
            clk_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            icnt_q    <= icnt_d;
            clk_en_q  <= clk_en_d;
            clk_ack_q <= clk_ack_d;
        end
    end

    assign gif.clk_en  = clk_en_q;
    assign gif.clk_ack = clk_ack_q;
    assign gif.state_o = state_q;

`ifdef CLK_GATE_STAT_EN
    logic [15:0] gated_cycles_q, gated_cycles_d;

    always_comb begin
        gated_cycles_d = gated_cycles_q;
        if (stat_clr) begin
            gated_cycles_d = '0;
        end else if ((state_q == StOff) && (gated_cycles_q != 16'hFFFF)) begin
            gated_cycles_d = gated_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) gated_cycles_q <= '0;
        else     gated_cycles_q <= gated_cycles_d;
    end

    assign gated_cycles = gated_cycles_q;
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus randomized activity vs a timing model.
`timescale 1ns/1ps
module tb_clk_gate_ctrl;
    localparam int W = 2;
    localparam int I = 8;

    logic in_clk = 1'b0;
    logic rst    = 1'b1;
    clk_gate_if gif ();
`ifdef CLK_GATE_STAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] gated_cycles;
`endif

    clk_gate_ctrl #(
        .WAKE_CYCLES(W),
        .IDLE_CYCLES(I),
        .CNT_W      (8)
    ) dut (
        .in_clk(in_clk),
        .rst   (rst),
        .gif   (gif)
`ifdef CLK_GATE_STAT_EN
        ,
        .stat_clr    (stat_clr),
        .gated_cycles(gated_cycles)
`endif
    );

    always #5 in_clk = ~in_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Timing model: clock on since the activating edge, ack once W edges have passed,
    // off once act has been low for I+1 consecutive edges after ack.
    bit m_en    = 1'b0;
    int m_since = 0;
    int m_run   = 0;
`ifdef CLK_GATE_STAT_EN
    logic [15:0] m_gc = '0;
`endif

    always @(posedge in_clk or posedge rst) begin
        if (rst) begin
            m_en    <= 1'b0;
            m_since <= 0;
            m_run   <= 0;
        end else if (!m_en) begin
            if (gif.run_req | gif.busy | gif.force_on) begin
                m_en    <= 1'b1;
                m_since <= 0;
                m_run   <= 0;
            end
        end else if (m_since < W) begin
            m_since <= m_since + 1;
        end else if (gif.run_req | gif.busy | gif.force_on) begin
            m_run <= 0;
        end else if (m_run == I) begin
            m_en <= 1'b0;
        end else begin
            m_run <= m_run + 1;
        end
    end

`ifdef CLK_GATE_STAT_EN
    always @(posedge in_clk or posedge rst) begin
        if (rst)                          m_gc <= '0;
        else if (stat_clr)                m_gc <= '0;
        else if (!m_en && m_gc != 16'hFFFF) m_gc <= m_gc + 16'd1;
    end
`endif

    function automatic logic m_ack();
        return m_en && (m_since >= W);
    endfunction

    function automatic logic [1:0] m_state();
        if (!m_en)       return 2'd0;
        if (!m_ack())    return 2'd1;
        if (m_run == 0)  return 2'd2;
        return 2'd3;
    endfunction

    always @(negedge in_clk) begin
        check("model_clk_en", {15'd0, gif.clk_en}, {15'd0, m_en});
        check("model_clk_ack", {15'd0, gif.clk_ack}, {15'd0, m_ack()});
        check("model_state_o", {14'd0, gif.state_o}, {14'd0, m_state()});
`ifdef CLK_GATE_STAT_EN
        check("model_gated_cycles", gated_cycles, m_gc);
`endif
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget);
        int n = 0;
        while (gif.state_o !== target && n < budget) begin
            tick();
            n++;
        end
        check("wait_state", {14'd0, gif.state_o}, {14'd0, target});
    endtask

    task automatic wake_to_on();
        gif.run_req = 1'b1;
        repeat (W + 1) tick();
        check("wake_ack", {15'd0, gif.clk_ack}, 16'd1);
        gif.run_req = 1'b0;
    endtask

    initial begin
        gif.run_req  = 1'b1;
        gif.busy     = 1'b0;
        gif.force_on = 1'b0;

        // Reset held with run_req high.
        #1;
        check("rst_en", {15'd0, gif.clk_en}, 16'd0);
        #9;
        check("rst_ack", {15'd0, gif.clk_ack}, 16'd0);
        #9;
        check("rst_state", {14'd0, gif.state_o}, 16'd0);
        #1 rst = 1'b0;
        tick();
        check("rst_release_en", {15'd0, gif.clk_en}, 16'd1);
        check("rst_release_state", {14'd0, gif.state_o}, 16'd1);
        gif.run_req = 1'b0;
        wait_state(2'd0, 100);

        // Wake and sleep at default timing.
        gif.run_req = 1'b1;
        tick();
        check("wake_en", {15'd0, gif.clk_en}, 16'd1);
        check("wake_ack_low", {15'd0, gif.clk_ack}, 16'd0);
        tick();
        check("wake_ack_low2", {15'd0, gif.clk_ack}, 16'd0);
        tick();
        check("wake_ack_high", {15'd0, gif.clk_ack}, 16'd1);
        check("wake_on_state", {14'd0, gif.state_o}, 16'd2);
        gif.run_req = 1'b0;
        for (int i = 0; i < I; i++) begin
            tick();
            check("idle_en_hold", {15'd0, gif.clk_en}, 16'd1);
        end
        tick();
        check("sleep_en", {15'd0, gif.clk_en}, 16'd0);
        check("sleep_state", {14'd0, gif.state_o}, 16'd0);

        // busy pulse in IDLE with icnt=3 restarts the full countdown.
        wake_to_on();
        repeat (5) tick();
        gif.busy = 1'b1;
        tick();
        check("reentry_state", {14'd0, gif.state_o}, 16'd2);
        gif.busy = 1'b0;
        tick();
        check("reentry_idle", {14'd0, gif.state_o}, 16'd3);
        for (int i = 0; i < I - 1; i++) begin
            tick();
            check("reentry_en_hold", {15'd0, gif.clk_en}, 16'd1);
        end
        tick();
        check("reentry_sleep", {15'd0, gif.clk_en}, 16'd0);

        // act arrives on the edge where icnt is zero: ON wins.
        wake_to_on();
        repeat (I) tick();
        check("coinc_idle", {14'd0, gif.state_o}, 16'd3);
        gif.busy = 1'b1;
        tick();
        check("coinc_on", {14'd0, gif.state_o}, 16'd2);
        check("coinc_en", {15'd0, gif.clk_en}, 16'd1);
        gif.busy = 1'b0;
        wait_state(2'd0, 40);

        // Debug override.
        gif.force_on = 1'b1;
        repeat (W + 1) tick();
        for (int i = 0; i < 47; i++) begin
            tick();
            check("force_state", {14'd0, gif.state_o}, 16'd2);
        end
        gif.force_on = 1'b0;
        for (int i = 0; i < I; i++) begin
            tick();
            check("force_release_hold", {15'd0, gif.clk_en}, 16'd1);
        end
        tick();
        check("force_release_off", {15'd0, gif.clk_en}, 16'd0);

        // Asynchronous reset mid-wake.
        gif.run_req = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("async_rst_en", {15'd0, gif.clk_en}, 16'd0);
        check("async_rst_state", {14'd0, gif.state_o}, 16'd0);
        tick();
        rst = 1'b0;
        gif.run_req = 1'b0;
        wait_state(2'd0, 10);

`ifdef CLK_GATE_STAT_EN
        stat_clr = 1'b1;
        tick();
        check("stat_clr", gated_cycles, 16'd0);
        stat_clr = 1'b0;
        repeat (30) tick();
        check("stat_30", gated_cycles, 16'd30);
`endif

        // Randomized activity with varying density and occasional resets.
        begin
            int dens = 10;
            for (int c = 0; c < 4000; c++) begin
                if (c % 64 == 0) dens = $urandom_range(0, 40);
                gif.run_req  = ($urandom_range(0, 99) < dens);
                gif.busy     = ($urandom_range(0, 99) < dens);
                gif.force_on = ($urandom_range(0, 199) < dens);
`ifdef CLK_GATE_STAT_EN
                stat_clr = ($urandom_range(0, 99) == 0);
`endif
                if ($urandom_range(0, 499) == 0) rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
